contador_ctrl: RTL and testbench
================================

Name: contador_ctrl

Overview:
Command sequencer for the 4-bit up/down counter with load (ports clock/reset/load/up_down/entrada/contador). It accepts one command at a time over a valid/ready port and drives the counter's control pins cycle by cycle. Supported commands are clear, load, count N steps in a chosen direction, and seek to a target value. Completion is reported with a one-cycle done pulse. The block sits between the system control logic and the counter instance. The counter is free-running whenever load=0, so this block holds the counter by reloading its current value.

Parameters:
WIDTH, 4, counter width; sizes cmd_data, cnt_entrada and cnt_value.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command; high only in IDLE.
cmd_op  in  2  opcode: 00 CLEAR, 01 LOAD, 10 STEP, 11 SEEK.
cmd_dir  in  1  STEP direction: 1 up, 0 down. Ignored for other opcodes.
cmd_data  in  WIDTH  LOAD value, STEP count N, or SEEK target.
abort  in  1  terminate a STEP or SEEK in progress.
cnt_value  in  WIDTH  counter output (contador).
cnt_clr_n  out  1  to the counter's reset pin (active-low clear); registered.
cnt_load  out  1  to the counter's load pin.
cnt_up_down  out  1  to the counter's up_down pin.
cnt_entrada  out  WIDTH  to the counter's entrada pin.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle completion pulse.
aborted  out  1  qualifies done; high for the same cycle when the command was aborted.

Behaviour:
- Reset (synchronous, active-high), while reset is high at an edge:
  - state <= IDLE, cnt_clr_n <= 0, done <= 0, aborted <= 0, step register cleared.
  - The counter is therefore held cleared.
  - cnt_clr_n returns to 1 at the first edge with reset low.
  - Reset mid-command discards the command; no done pulse.
- Hold rule: in IDLE, and in any non-counting cycle, drive cnt_load=1, cnt_entrada=cnt_value, cnt_up_down=0, so the counter keeps its value.
- Accept: a command is accepted at an edge where cmd_valid=1 and cmd_ready=1 (IDLE). cmd_op, cmd_dir and cmd_data are registered at that edge (E0). Inputs are ignored while busy.
- States: IDLE, CLR, LOAD, RUN_STEP, RUN_SEEK.
- CLEAR: at E0, cnt_clr_n <= 0 and state <= CLR. At E1, cnt_clr_n <= 1, state <= IDLE, done <= 1. Counter reads 0 from E0 onward.
- LOAD: state LOAD for one cycle with cnt_load=1, cnt_entrada=registered data. The counter takes the value at E1; state <= IDLE, done <= 1.
- STEP N:
  - N=0: state stays IDLE and done <= 1 at E0.
  - Otherwise RUN_STEP drives cnt_load=0, cnt_up_down=dir, and steps_left decrements at each edge.
  - At the Nth counting edge, state <= IDLE and done <= 1.
  - The counter wraps modulo 2^WIDTH; wrap is not an error.
- SEEK T: each RUN_SEEK cycle compares cnt_value with T.
  - Not equal: cnt_load=0, cnt_up_down=(T>cnt_value) unsigned.
  - Equal: apply the hold rule; at the next edge state <= IDLE and done <= 1.
  - The direction never crosses the wrap boundary. The counter makes |T-start| counting edges and the seek takes |T-start|+1 edges total.
- abort:
  - Sampled only in RUN_STEP/RUN_SEEK, and has priority over the count in that cycle.
  - The cycle applies the hold rule; at the next edge state <= IDLE, done <= 1, aborted <= 1.
  - Ignored in IDLE, CLR and LOAD.
- done/aborted are registered and high for exactly one cycle, during which cmd_ready=1. A new command may be accepted in that same cycle.
- busy = (state != IDLE).

Test Plan:
- Reset: assert reset for 3 cycles with the counter at 9, then release -> cnt_clr_n=0 during reset, counter=0, cnt_clr_n=1 one cycle after release, cmd_ready=1, done never pulses.
- LOAD 0xA then STEP up N=3 -> counter 0xA, then 0xB, 0xC, 0xD on consecutive edges. done pulses once after each command; counter holds 0xD afterwards for 10+ cycles.
- Wrap: LOAD 14, then STEP up N=3 -> counter 15, 0, 1; done after the third edge. Also STEP down N=2 from 1 -> 0, 15.
- SEEK: from 3 to 7 -> 4 counting edges, done one cycle after reaching 7. From 12 to 5 -> counts down 7 edges. SEEK to the current value -> done after 1 edge with no change.
- Abort: STEP up N=10 from 0, abort on the 4th RUN cycle -> counter frozen at 3, done=1 with aborted=1, busy falls.
- Edge cases: cmd_valid held high while busy -> only one command accepted. STEP N=0 -> done at once, counter unchanged. Back-to-back CLEAR then LOAD 5 issued in the done cycle -> counter 0 then 5.

Source files
------------

// File: rtl/contador_ctrl.sv
// contador_ctrl: command sequencer for the 4-bit up/down counter with load.
// Accepts CLEAR / LOAD / STEP / SEEK commands over valid/ready and drives the
// counter's clear, load, up_down and entrada pins cycle by cycle. The counter
// free-runs whenever load=0, so every non-counting cycle reloads its value.
module contador_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_clr_n,
  output logic             cnt_load,
  output logic             cnt_up_down,
  output logic [WIDTH-1:0] cnt_entrada,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_SEEK  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLR      = 3'd1,
    S_LOAD     = 3'd2,
    S_RUN_STEP = 3'd3,
    S_RUN_SEEK = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   steps_q, steps_d;
  logic               clr_n_q, clr_n_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  // State and command registers; reset holds the counter cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      dir_q     <= 1'b0;
      steps_q   <= '0;
      clr_n_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      steps_q   <= steps_d;
      clr_n_q   <= clr_n_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic and counter pin drive; default cycle holds the counter.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dir_d       = dir_q;
    steps_d     = steps_q;
    clr_n_d     = 1'b1;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    cnt_load    = 1'b1;
    cnt_up_down = 1'b0;
    cnt_entrada = cnt_value;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          data_d = cmd_data;
          dir_d  = cmd_dir;
          unique case (cmd_op)
            OP_CLEAR: begin
              clr_n_d = 1'b0;
              state_d = S_CLR;
            end
            OP_LOAD: begin
              state_d = S_LOAD;
            end
            OP_STEP: begin
              steps_d = cmd_data;
              if (cmd_data == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = S_RUN_STEP;
              end
            end
            OP_SEEK: begin
              state_d = S_RUN_SEEK;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_CLR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      S_LOAD: begin
        cnt_entrada = data_q;
        state_d     = S_IDLE;
        done_d      = 1'b1;
      end

      S_RUN_STEP: begin
        if (abort) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          cnt_load    = 1'b0;
          cnt_up_down = dir_q;
          steps_d     = steps_q - WIDTH'(1);
          if (steps_q == WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN_SEEK: begin
        if (abort) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_value == data_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          // Unsigned compare keeps the seek from crossing the wrap boundary.
          cnt_load    = 1'b0;
          cnt_up_down = (data_q > cnt_value);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign cnt_clr_n = clr_n_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Testbench for contador_ctrl: includes a behavioural model of the 4-bit
// counter (async active-low clear) and a scoreboard of per-command results.
module tb_contador_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_SEEK  = 2'b11;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_data;
  logic             abort;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_clr_n;
  logic             cnt_load;
  logic             cnt_up_down;
  logic [WIDTH-1:0] cnt_entrada;
  logic             busy;
  logic             done;
  logic             aborted;

  always #5 clock = ~clock;

  contador_ctrl #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_dir     (cmd_dir),
    .cmd_data    (cmd_data),
    .abort       (abort),
    .cnt_value   (cnt_value),
    .cnt_clr_n   (cnt_clr_n),
    .cnt_load    (cnt_load),
    .cnt_up_down (cnt_up_down),
    .cnt_entrada (cnt_entrada),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  // Counter model: async clear, load, else free-running up/down.
  logic [WIDTH-1:0] contador;
  always @(posedge clock or negedge cnt_clr_n) begin
    if (!cnt_clr_n)       contador <= '0;
    else if (cnt_load)    contador <= cnt_entrada;
    else if (cnt_up_down) contador <= contador + WIDTH'(1);
    else                  contador <= contador - WIDTH'(1);
  end
  assign cnt_value = contador;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic             ab;
    int unsigned      done_cyc;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse is matched to the oldest command.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("done_value", 32'(cnt_value), 32'(e.val));
        chk("done_aborted", 32'(aborted), 32'(e.ab));
        chk("done_cycle", cyc, e.done_cyc);
        chk("done_ready", 32'(cmd_ready), 32'(1));
      end
    end else if (!reset && aborted) begin
      chk("aborted_stray", 32'(aborted), 32'(0));
    end
  end

  // Drive one command for the accept edge; returns at the following negedge.
  task automatic send(input logic [1:0] op, input logic dir, input logic [WIDTH-1:0] data,
                      input logic [WIDTH-1:0] exp_val, input int unsigned lat, input logic exp_ab);
    exp_t e;
    chk("ready_at_send", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dir   = dir;
    cmd_data  = data;
    e.val      = exp_val;
    e.ab       = exp_ab;
    e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic do_clear();
    send(OP_CLEAR, 1'b0, '0, '0, 1, 1'b0);
    exp_cnt = '0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    send(OP_LOAD, 1'b0, v, v, 1, 1'b0);
    exp_cnt = v;
  endtask

  task automatic do_step(input logic dir, input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] v;
    v = dir ? exp_cnt + n : exp_cnt - n;
    send(OP_STEP, dir, n, v, 32'(n), 1'b0);
    exp_cnt = v;
  endtask

  task automatic do_seek(input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] diff;
    diff = (t > exp_cnt) ? t - exp_cnt : exp_cnt - t;
    send(OP_SEEK, 1'b0, t, t, 32'(diff) + 1, 1'b0);
    exp_cnt = t;
  endtask

  // Wait (bounded) until every pushed command has produced its done pulse.
  task automatic drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dir = 1'b0; cmd_data = '0; abort = 1'b0;
    exp_cnt = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset with the counter at 9.
    do_load(4'd9);
    drain();
    chk("pre_reset_cnt", 32'(cnt_value), 32'(9));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_clr_n", 32'(cnt_clr_n), 32'(0));
      chk("rst_cnt", 32'(cnt_value), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
    end
    reset = 1'b0;
    exp_cnt = '0;
    @(negedge clock);
    chk("rel_clr_n", 32'(cnt_clr_n), 32'(1));
    chk("rel_ready", 32'(cmd_ready), 32'(1));
    chk("rel_busy", 32'(busy), 32'(0));

    // LOAD 0xA then STEP up 3.
    do_load(4'hA);
    drain();
    chk("load_a", 32'(cnt_value), 32'(4'hA));
    do_step(1'b1, 4'd3);
    chk("step_busy", 32'(busy), 32'(1));
    @(negedge clock); chk("step_b", 32'(cnt_value), 32'(4'hB));
    @(negedge clock); chk("step_c", 32'(cnt_value), 32'(4'hC));
    @(negedge clock); chk("step_d", 32'(cnt_value), 32'(4'hD));
    drain();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_d", 32'(cnt_value), 32'(4'hD));
    end

    // Wrap up and down.
    do_load(4'd14);
    drain();
    do_step(1'b1, 4'd3);
    @(negedge clock); chk("wrap_15", 32'(cnt_value), 32'(15));
    @(negedge clock); chk("wrap_0", 32'(cnt_value), 32'(0));
    @(negedge clock); chk("wrap_1", 32'(cnt_value), 32'(1));
    drain();
    do_step(1'b0, 4'd2);
    @(negedge clock); chk("down_0", 32'(cnt_value), 32'(0));
    @(negedge clock); chk("down_15", 32'(cnt_value), 32'(15));
    drain();

    // SEEK up, down and to the current value.
    do_load(4'd3);
    drain();
    do_seek(4'd7);
    drain();
    do_load(4'd12);
    drain();
    do_seek(4'd5);
    drain();
    do_seek(4'd5);
    drain();
    chk("seek_same", 32'(cnt_value), 32'(5));

    // Abort STEP up 10 on the 4th run cycle.
    do_clear();
    drain();
    send(OP_STEP, 1'b1, 4'd10, 4'd3, 4, 1'b1);
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_cnt", 32'(cnt_value), 32'(3));
    exp_cnt = 4'd3;
    drain();

    // abort is ignored outside RUN states.
    abort = 1'b1;
    do_load(4'd6);
    drain();
    abort = 1'b0;

    // cmd_valid held high while busy: only the first command is taken.
    do_step(1'b1, 4'd3);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 4'd0;
    repeat (2) @(negedge clock);
    cmd_valid = 1'b0;
    drain();
    chk("held_valid_cnt", 32'(cnt_value), 32'(exp_cnt));
    repeat (5) @(negedge clock);
    chk("held_valid_idle", 32'(busy), 32'(0));

    // STEP N=0 completes at once.
    do_step(1'b1, 4'd0);
    drain();
    chk("step0_cnt", 32'(cnt_value), 32'(9));

    // Back-to-back CLEAR then LOAD 5 in the done cycle.
    do_clear();
    chk("clear_immediate", 32'(cnt_value), 32'(0));
    @(negedge clock);
    chk("clear_done", 32'(done), 32'(1));
    do_load(4'd5);
    drain();
    chk("b2b_load", 32'(cnt_value), 32'(5));

    // Reset mid-command discards it with no done pulse.
    do_step(1'b1, 4'd10);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clock);
    chk("midrst_cnt", 32'(cnt_value), 32'(0));
    reset = 1'b0;
    exp_cnt = '0;
    repeat (12) @(negedge clock);
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_clr_n", 32'(cnt_clr_n), 32'(1));
    chk("midrst_hold", 32'(cnt_value), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
